uart_rx: RTL

- Memory-mapped serial receiver slave on the shared system bus; the receive-side counterpart of the UART transmitter.
- Oversamples the asynchronous RxD line and deframes 8N1 characters.
- Buffers received bytes in a small FIFO that the CPU reads over the bus.
- Raises a level interrupt request toward the CPU interrupt path while data is pending.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_fifo.sv | 72 +++++++
 rtl/uart_rx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slave.
// Holds the register offsets, the STATUS bit positions, the receiver FSM
// state encoding and the bus read/write encoding.
// No ports (package).
package uart_pkg;

    // Word offsets from the slave base address
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // STATUS register bit positions; the FIFO count occupies bits 3:0
    localparam int STAT_OVERRUN  = 7;
    localparam int STAT_FRAME_ER = 6;
    localparam int STAT_BUSY     = 5;
    localparam int STAT_FULL     = 4;

    // BUS_RW encoding
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Receiver FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO buffering received characters.
// A push while full is dropped unless a pop happens in the same cycle, in
// which case both take effect and the count stays put.
// Ports: clk, clr (sync active-high reset), push/wdata (write side),
//        pop/rdata (read side, rdata is the current head), full, empty,
//        count (AW+1 bits).
module uart_rx_fifo #(
    parameter int AW = 2,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   ZERO_CNT = {(AW+1){1'b0}};
    localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    // Pointer and occupancy update; a pop frees the slot the push needs
    always_comb begin
        do_pop_s  = pop & (count_q != ZERO_CNT);
        do_push_s = push & ((count_q != FULL_CNT) | do_pop_s);
        wptr_d    = do_push_s ? (wptr_q + PTR_ONE) : wptr_q;
        rptr_d    = do_pop_s  ? (rptr_q + PTR_ONE) : rptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and storage registers
    always_ff @(posedge clk) begin
        if (clr) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= ZERO_CNT;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (do_push_s) begin
                mem_q[wptr_q] <= wdata;
            end
        end
    end

    assign rdata = mem_q[rptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == ZERO_CNT);
    assign count = count_q;

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 serial receiver slave.
// RxD is synchronized, oversampled at CLK_DIV clocks per bit and deframed;
// good characters go into a small FIFO that the CPU drains over the bus.
// Ports: clk, clr (sync active-high reset), BUS_addr/BUS_req/BUS_RW (access
//        request), BUS_data/BUS_ready (tri-stated, driven only in this
//        slave's ready cycle), RxD (serial input), rx_int (level irq),
//        rx_busy (frame in progress).
module uart_rx
    import uart_pkg::*;
#(
    parameter logic [29:0] BASE_ADDR = 30'h0000_4000,
    parameter int          CLK_DIV   = 16,
    parameter int          FIFO_AW   = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] BUS_addr,
    inout  wire  [31:0] BUS_data,
    input  logic        BUS_req,
    inout  wire         BUS_ready,
    input  logic        BUS_RW,
    input  logic        RxD,
    output logic        rx_int,
    output logic        rx_busy
);

    localparam logic [15:0] DIV_FULL = 16'(CLK_DIV - 1);
    localparam logic [15:0] DIV_HALF = 16'(CLK_DIV / 2 - 1);

    rx_state_e      state_q, state_d;
    logic           rx_s1_q, rx_s2_q;
    logic [15:0]    cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           push_s, ferr_set_s;

    logic           ready_q, ready_d;
    logic           rw_q, rw_d;
    logic [1:0]     off_q, off_d;
    logic [2:0]     wbits_q, wbits_d;   // {bit7, bit6, bit0} of the write data
    logic           overrun_q, overrun_d;
    logic           frame_err_q, frame_err_d;
    logic           int_en_q, int_en_d;
    logic           rx_int_q, rx_int_d;
    logic           busy_q, busy_d;

    logic           sel_s, rd_s, wr_s, pop_s, ovr_set_s;
    logic [31:0]    rdata_s;
    logic [7:0]     fifo_head_s;
    logic           fifo_full_s, fifo_empty_s;
    logic [FIFO_AW:0] fifo_count_s;

    uart_rx_fifo #(.AW(FIFO_AW), .W(8)) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (shreg_q),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Receiver deframer: half-bit wait to centre on the start bit, then one
    // sample per bit period
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        push_s     = 1'b0;
        ferr_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s2_q) begin
                    state_d = ST_START;
                    cnt_d   = DIV_HALF;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == 16'd0) begin
                    if (!rx_s2_q) begin
                        state_d = ST_DATA;
                        cnt_d   = DIV_FULL;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;   // line went high again: glitch
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == 16'd0) begin
                    shreg_d[idx_q] = rx_s2_q;
                    cnt_d          = DIV_FULL;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == 16'd0) begin
                    if (rx_s2_q) begin
                        push_s = 1'b1;
                    end else begin
                        ferr_set_s = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus slave: register the access in cycle N, complete it in cycle N+1
    always_comb begin
        sel_s   = BUS_req & ~ready_q &
                  (BUS_addr[31:2] == {2'b00, BASE_ADDR[29:2]});
        ready_d = sel_s;
        if (sel_s) begin
            rw_d    = BUS_RW;
            off_d   = BUS_addr[1:0];
            wbits_d = {BUS_data[7], BUS_data[6], BUS_data[0]};
        end else begin
            rw_d    = rw_q;
            off_d   = off_q;
            wbits_d = wbits_q;
        end
        rd_s  = ready_q & (rw_q == RW_READ);
        wr_s  = ready_q & (rw_q == RW_WRITE);
        pop_s = rd_s & (off_q == REG_DATA) & ~fifo_empty_s;
        // A push into a full FIFO is only lost when no pop frees a slot
        ovr_set_s = push_s & fifo_full_s & ~pop_s;

        // Error flags: a new error wins over a simultaneous clear
        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (wr_s && (off_q == REG_STATUS) && wbits_q[2]) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        if (ferr_set_s) begin
            frame_err_d = 1'b1;
        end else if (wr_s && (off_q == REG_STATUS) && wbits_q[1]) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
        if (wr_s && (off_q == REG_CTRL)) begin
            int_en_d = wbits_q[0];
        end else begin
            int_en_d = int_en_q;
        end

        rx_int_d = int_en_q & ~fifo_empty_s;
        busy_d   = (state_d != ST_IDLE);
    end

    // Read data mux, valid during the ready cycle
    always_comb begin
        case (off_q)
            REG_DATA:   rdata_s = {23'd0, ~fifo_empty_s,
                                   fifo_empty_s ? 8'd0 : fifo_head_s};
            REG_STATUS: rdata_s = {24'd0, overrun_q, frame_err_q, busy_q,
                                   fifo_full_s, 4'(fifo_count_s)};
            REG_CTRL:   rdata_s = {31'd0, int_en_q};
            default:    rdata_s = 32'd0;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            cnt_q       <= 16'd0;
            idx_q       <= 3'd0;
            shreg_q     <= 8'd0;
            ready_q     <= 1'b0;
            rw_q        <= RW_READ;
            off_q       <= 2'd0;
            wbits_q     <= 3'd0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            int_en_q    <= 1'b0;
            rx_int_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_s1_q     <= RxD;
            rx_s2_q     <= rx_s1_q;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            ready_q     <= ready_d;
            rw_q        <= rw_d;
            off_q       <= off_d;
            wbits_q     <= wbits_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            int_en_q    <= int_en_d;
            rx_int_q    <= rx_int_d;
            busy_q      <= busy_d;
        end
    end

    assign BUS_ready = ready_q ? 1'b1 : 1'bz;
    assign BUS_data  = (ready_q && (rw_q == RW_READ)) ? rdata_s : 32'bz;
    assign rx_int    = rx_int_q;
    assign rx_busy   = busy_q;

endmodule
